// File: rtl/decode_stage.sv
// Registered RV32I/RV64I decode stage with valid/ready on both sides and a single output register.
// Optional feature: define MUL_DIV_EN to decode the M-extension (funct7=0000001) to alu_op 16-23.
module decode_stage #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         instruction,
    input  logic [XLEN-1:0]     pc,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic [4:0]          rd,
    output logic [XLEN-1:0]     immediate,
    output logic                alu_src_imm,
    output logic [2:0]          load_op,
    output logic [2:0]          store_op,
    output logic [2:0]          branch_op,
    output logic                mem_read_en,
    output logic                mem_write_en,
    output logic                reg_write_en,
    output logic                branch,
    output logic                jump,
    output logic                word_op,
    output logic                illegal
);

    localparam bit RV64 = (XLEN == 64);

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_SLL   = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_SLT   = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] ALU_SLTU  = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] ALU_XOR   = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] ALU_SRL   = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] ALU_SRA   = ALU_OP_W'(7);
    localparam logic [ALU_OP_W-1:0] ALU_OR    = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] ALU_AND   = ALU_OP_W'(9);
    localparam logic [ALU_OP_W-1:0] ALU_PASSB = ALU_OP_W'(10);
    localparam logic [ALU_OP_W-1:0] ALU_ADDPC = ALU_OP_W'(11);
`ifdef MUL_DIV_EN
    // MUL..REMU occupy 16+funct3, so the M-extension funct3 maps straight across.
    localparam logic [ALU_OP_W-1:0] ALU_MUL   = ALU_OP_W'(16);
`endif

    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [ALU_OP_W-1:0] alu_op;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [XLEN-1:0]     imm;
        logic                alu_src_imm;
        logic [2:0]          load_op;
        logic [2:0]          store_op;
        logic [2:0]          branch_op;
        logic                mem_read_en;
        logic                mem_write_en;
        logic                reg_write_en;
        logic                branch;
        logic                jump;
        logic                word_op;
        logic                illegal;
    } bundle_t;

    bundle_t dec;
    bundle_t held;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [6:0]      shf;
    logic            bad;
    logic            sra_sel;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode  = instruction[6:0];
    assign funct3  = instruction[14:12];
    assign funct7  = instruction[31:25];
    // Shift-immediate function field; RV64 lends inst[25] to the 6-bit shamt.
    assign shf     = {instruction[31:26], RV64 ? 1'b0 : instruction[25]};
    assign sra_sel = instruction[30] && (funct3 == 3'b101);

    assign imm_i = XLEN'($signed(instruction[31:20]));
    assign imm_s = XLEN'($signed({instruction[31:25], instruction[11:7]}));
    assign imm_b = XLEN'($signed({instruction[31], instruction[7], instruction[30:25],
                                  instruction[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({instruction[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({instruction[31], instruction[19:12], instruction[20],
                                  instruction[30:21], 1'b0}));

    function automatic logic [ALU_OP_W-1:0] base_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  base_alu = alt ? ALU_SUB : ALU_ADD;
            3'b001:  base_alu = ALU_SLL;
            3'b010:  base_alu = ALU_SLT;
            3'b011:  base_alu = ALU_SLTU;
            3'b100:  base_alu = ALU_XOR;
            3'b101:  base_alu = alt ? ALU_SRA : ALU_SRL;
            3'b110:  base_alu = ALU_OR;
            default: base_alu = ALU_AND;
        endcase
    endfunction

    // Register fields are always reported raw, even for formats that reuse those bits.
    always_comb begin
        dec        = '0;
        dec.pc     = pc;
        dec.rs1    = instruction[19:15];
        dec.rs2    = instruction[24:20];
        dec.rd     = instruction[11:7];
        dec.alu_op = ALU_ADD;
        bad        = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec.alu_op = ALU_PASSB;  dec.imm = imm_u;
                dec.alu_src_imm = 1'b1;  dec.reg_write_en = 1'b1;
            end
            OPC_AUIPC: begin
                dec.alu_op = ALU_ADDPC;  dec.imm = imm_u;
                dec.alu_src_imm = 1'b1;  dec.reg_write_en = 1'b1;
            end
            OPC_JAL: begin
                dec.alu_op = ALU_ADDPC;  dec.imm = imm_j;  dec.alu_src_imm = 1'b1;
                dec.reg_write_en = 1'b1; dec.jump = 1'b1;
            end
            OPC_JALR: begin
                dec.alu_op = ALU_ADDPC;  dec.imm = imm_i;  dec.alu_src_imm = 1'b1;
                dec.reg_write_en = 1'b1; dec.jump = 1'b1;
                bad = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec.alu_op = ALU_SUB;  dec.imm = imm_b;
                dec.branch = 1'b1;     dec.branch_op = funct3;
                bad = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                dec.imm = imm_i;  dec.alu_src_imm = 1'b1;  dec.load_op = funct3;
                dec.mem_read_en = 1'b1;  dec.reg_write_en = 1'b1;
                bad = (funct3 == 3'b111) || (!RV64 && (funct3 == 3'b011 || funct3 == 3'b110));
            end
            OPC_STORE: begin
                dec.imm = imm_s;  dec.alu_src_imm = 1'b1;  dec.store_op = funct3;
                dec.mem_write_en = 1'b1;
                bad = funct3[2] || (!RV64 && funct3 == 3'b011);
            end
            OPC_OPIMM: begin
                dec.alu_op = base_alu(funct3, sra_sel);  dec.imm = imm_i;
                dec.alu_src_imm = 1'b1;  dec.reg_write_en = 1'b1;
                if (funct3 == 3'b001)
                    bad = (shf != F7_BASE);
                else if (funct3 == 3'b101)
                    bad = !(shf == F7_BASE || shf == F7_ALT);
            end
            OPC_OP: begin
                dec.reg_write_en = 1'b1;
                case (funct7)
                    F7_BASE: dec.alu_op = base_alu(funct3, 1'b0);
                    F7_ALT: begin
                        dec.alu_op = base_alu(funct3, 1'b1);
                        bad = !(funct3 == 3'b000 || funct3 == 3'b101);
                    end
                    F7_MULDIV: begin
`ifdef MUL_DIV_EN
                        dec.alu_op = ALU_MUL + ALU_OP_W'(funct3);
`else
                        bad = 1'b1;
`endif
                    end
                    default: bad = 1'b1;
                endcase
            end
            OPC_OPIMM32: begin
                if (RV64) begin
                    dec.word_op = 1'b1;  dec.alu_op = base_alu(funct3, sra_sel);
                    dec.imm = imm_i;  dec.alu_src_imm = 1'b1;  dec.reg_write_en = 1'b1;
                    case (funct3)
                        3'b000:  bad = 1'b0;
                        3'b001:  bad = (funct7 != F7_BASE);
                        3'b101:  bad = !(funct7 == F7_BASE || funct7 == F7_ALT);
                        default: bad = 1'b1;
                    endcase
                end else begin
                    bad = 1'b1;
                end
            end
            OPC_OP32: begin
                if (RV64) begin
                    dec.word_op = 1'b1;  dec.reg_write_en = 1'b1;
                    case (funct7)
                        F7_BASE: begin
                            dec.alu_op = base_alu(funct3, 1'b0);
                            bad = !(funct3 inside {3'b000, 3'b001, 3'b101});
                        end
                        F7_ALT: begin
                            dec.alu_op = base_alu(funct3, 1'b1);
                            bad = !(funct3 inside {3'b000, 3'b101});
                        end
                        F7_MULDIV: begin
`ifdef MUL_DIV_EN
                            dec.alu_op = ALU_MUL + ALU_OP_W'(funct3);
                            bad = funct3 inside {3'b001, 3'b010, 3'b011};
`else
                            bad = 1'b1;
`endif
                        end
                        default: bad = 1'b1;
                    endcase
                end else begin
                    bad = 1'b1;
                end
            end
            // FENCE/SYSTEM and anything else are not handled here and trap as illegal.
            default: bad = 1'b1;
        endcase
        if (instruction[1:0] != 2'b11)
            bad = 1'b1;
        dec.illegal = bad;
        if (bad) begin
            dec.reg_write_en = 1'b0;
            dec.mem_read_en  = 1'b0;
            dec.mem_write_en = 1'b0;
            dec.jump         = 1'b0;
            dec.branch       = 1'b0;
        end
        if (dec.rd == 5'd0)
            dec.reg_write_en = 1'b0;
    end

    assign in_ready = !out_valid || out_ready;

    // Flush wins over a simultaneous accept; the held payload is left as-is behind out_valid=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            held      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            held      <= dec;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_pc       = held.pc;
    assign alu_op       = held.alu_op;
    assign rs1          = held.rs1;
    assign rs2          = held.rs2;
    assign rd           = held.rd;
    assign immediate    = held.imm;
    assign alu_src_imm  = held.alu_src_imm;
    assign load_op      = held.load_op;
    assign store_op     = held.store_op;
    assign branch_op    = held.branch_op;
    assign mem_read_en  = held.mem_read_en;
    assign mem_write_en = held.mem_write_en;
    assign reg_write_en = held.reg_write_en;
    assign branch       = held.branch;
    assign jump         = held.jump;
    assign word_op      = held.word_op;
    assign illegal      = held.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage at XLEN=32; expectations are hand-decoded per instruction.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instruction = '0;
    logic [31:0] pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [4:0]  alu_op;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] immediate;
    logic        alu_src_imm;
    logic [2:0]  load_op, store_op, branch_op;
    logic        mem_read_en, mem_write_en, reg_write_en, branch, jump, word_op, illegal;

    decode_stage #(.XLEN(32), .ALU_OP_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc(pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .alu_op(alu_op), .rs1(rs1), .rs2(rs2), .rd(rd), .immediate(immediate),
        .alu_src_imm(alu_src_imm), .load_op(load_op), .store_op(store_op),
        .branch_op(branch_op), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .reg_write_en(reg_write_en), .branch(branch), .jump(jump),
        .word_op(word_op), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // flag order: {mem_read_en, mem_write_en, reg_write_en, branch, jump, word_op, illegal}
    localparam logic [6:0] F_RD = 7'b1000000, F_WR = 7'b0100000, F_RW = 7'b0010000;
    localparam logic [6:0] F_BR = 7'b0001000, F_J  = 7'b0000100, F_IL = 7'b0000001;

    typedef struct {
        logic [31:0] inst;
        logic [68:0] exp;
    } vec_t;

    vec_t          tbl[$];
    logic [100:0]  sb[$];
    logic [68:0]   cur_exp = '0;
    logic [68:0]   obs;
    logic [31:0]   next_pc = 32'h1000;
    int            n_chk = 0, n_bad = 0, n_out = 0, cyc = 0;

    assign obs = {alu_op, rd, rs1, rs2, immediate, alu_src_imm, load_op, store_op, branch_op,
                  mem_read_en, mem_write_en, reg_write_en, branch, jump, word_op, illegal};

    function automatic logic [68:0] mk(input int alu, input int d, input int s1, input int s2,
                                       input logic [31:0] imm, input logic src,
                                       input logic [2:0] lo, input logic [2:0] so,
                                       input logic [2:0] bo, input logic [6:0] fl);
        return {5'(alu), 5'(d), 5'(s1), 5'(s2), imm, src, lo, so, bo, fl};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output side: compare on transfer, check hold on stall, drop a killed bundle; input side: push on accept.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", out_valid, 1'b0);
                end else if (flush && !out_ready) begin
                    void'(sb.pop_front());
                end else begin
                    chk(out_ready ? "bundle" : "stall_hold", {out_pc, obs}, sb[0]);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready && !flush)
                sb.push_back({pc, cur_exp});
        end
    end

    task automatic present(input int idx);
        instruction = tbl[idx].inst;
        cur_exp     = tbl[idx].exp;
        pc          = next_pc;
        in_valid    = 1'b1;
    endtask

    task automatic send(input int idx);
        bit ok = 1'b0;
        present(idx);
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) chk("send_accept", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        next_pc  = next_pc + 32'd4;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        chk("drain_empty", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, n0;
        tbl.push_back('{32'hFFB10093, mk(0, 1, 2, 27, 32'hFFFFFFFB, 1, 0, 0, 0, F_RW)});   // addi x1,x2,-5
        tbl.push_back('{32'h00512423, mk(0, 8, 2, 5, 32'd8, 1, 0, 2, 0, F_WR)});           // sw x5,8(x2)
`ifdef MUL_DIV_EN
        tbl.push_back('{32'h022081B3, mk(16, 3, 1, 2, 32'd0, 0, 0, 0, 0, F_RW)});          // mul x3,x1,x2
`else
        tbl.push_back('{32'h022081B3, mk(0, 3, 1, 2, 32'd0, 0, 0, 0, 0, F_IL)});
`endif
        tbl.push_back('{32'h00000000, mk(0, 0, 0, 0, 32'd0, 0, 0, 0, 0, F_IL)});
        tbl.push_back('{32'h0000001B, mk(0, 0, 0, 0, 32'd0, 0, 0, 0, 0, F_IL)});           // addiw on RV32
        tbl.push_back('{32'h40310233, mk(1, 4, 2, 3, 32'd0, 0, 0, 0, 0, F_RW)});           // sub x4,x2,x3
        tbl.push_back('{32'h40335293, mk(7, 5, 6, 3, 32'h403, 1, 0, 0, 0, F_RW)});         // srai x5,x6,3
        tbl.push_back('{32'h02009093, mk(2, 1, 1, 0, 32'd32, 1, 0, 0, 0, F_IL)});          // slli shamt 32
        tbl.push_back('{32'h800003B7, mk(10, 7, 0, 0, 32'h80000000, 1, 0, 0, 0, F_RW)});   // lui x7,0x80000
        tbl.push_back('{32'hFFDFF0EF, mk(11, 1, 31, 29, 32'hFFFFFFFC, 1, 0, 0, 0, F_RW | F_J)}); // jal -4
        tbl.push_back('{32'h00208463, mk(1, 8, 1, 2, 32'd8, 0, 0, 0, 0, F_BR)});           // beq +8
        tbl.push_back('{32'hFE41EFE3, mk(1, 31, 3, 4, 32'hFFFFFFFE, 0, 0, 0, 6, F_BR)});   // bltu -2
        tbl.push_back('{32'hFFF42303, mk(0, 6, 8, 31, 32'hFFFFFFFF, 1, 2, 0, 0, F_RD | F_RW)}); // lw -1
        tbl.push_back('{32'h00000013, mk(0, 0, 0, 0, 32'd0, 1, 0, 0, 0, 7'b0)});           // nop, rd=0
        tbl.push_back('{32'h000010E7, mk(11, 1, 0, 0, 32'd0, 1, 0, 0, 0, F_IL)});          // jalr funct3=1
        tbl.push_back('{32'hFFB10091, mk(0, 1, 2, 27, 32'd0, 0, 0, 0, 0, F_IL)});          // inst[1:0]=01
        tbl.push_back('{32'h12345517, mk(11, 10, 8, 3, 32'h12345000, 1, 0, 0, 0, F_RW)});  // auipc

        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_outputs", {out_pc, obs}, '0);
        #1 rst = 1'b0;

        // back-to-back stream, one accept per cycle
        @(posedge clk); #1;
        out_ready = 1'b1;
        t0 = cyc;
        n0 = n_out;
        for (int i = 0; i < tbl.size(); i++) send(i);
        chk("stream_cycles", cyc - t0, tbl.size());
        @(negedge clk); #1;
        chk("stream_no_bubble", n_out - n0, tbl.size());
        wait_drain();

        // stall with sw held, then simultaneous drain + accept of addi
        out_ready = 1'b0;
        send(1);
        present(0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_store_op", store_op, 3'd2);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        next_pc  = next_pc + 32'd4;
        @(negedge clk);
        chk("drain_accept_valid", out_valid, 1'b1);
        wait_drain();

        // flush beats an incoming instruction on an empty stage
        present(8);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_incoming", out_valid, 1'b0);
        @(posedge clk); #1;

        // flush kills a stalled bundle and the incoming one
        out_ready = 1'b0;
        send(12);
        present(8);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_held", out_valid, 1'b0);
        @(posedge clk); #1;

        // asynchronous reset in the middle of a stall
        send(16);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_stall_valid", out_valid, 1'b0);
        chk("rst_stall_ready", in_ready, 1'b1);
        chk("rst_stall_outputs", {out_pc, obs}, '0);
        sb.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(6);
        wait_drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
